wishbone_master: RTL and testbench

- Pipelined Wishbone initiator that drives one port of the dual-port RAM slave, or any slave with the same 11-bit byte-address, 32-bit data, stall and ack signalling.
- Accepts single-beat read/write commands on a valid/ready interface and issues them as pipelined Wishbone requests.
- Tracks outstanding requests and returns in-order responses to the local client.
- Instantiated once per RAM port in the test SoC and the DMA path.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_tag_fifo.sv | 64 ++++++
 rtl/wishbone_master.sv | 156 +++++++++++++++
 tb/tb_wishbone_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone widths, request record and initiator state encoding.
package wb_pkg;

   localparam int WB_ADDR_W = 11;
   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef struct packed {
      logic                 we;
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
      logic [WB_SEL_W-1:0]  sel;
   } wb_req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      ABORT  = 2'd2
   } wbm_state_t;

endpackage

// File: rtl/wb_tag_fifo.sv
// 1-bit tag FIFO holding the we bit of each issued, not-yet-acked request.
module wb_tag_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic                         i_push_data,
   input  logic                         i_pop,
   output logic                         o_pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_empty;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   // Push into a full FIFO or pop from an empty one is fine when paired.
   assign w_do_push = i_push & (~w_full | i_pop);
   assign w_do_pop  = i_pop & (~w_empty | i_push);

   assign o_pop_data = w_empty ? i_push_data : r_mem[r_rd_ptr];
   assign o_count    = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wishbone_master.sv
// Pipelined Wishbone initiator with in-order responses.
// Optional watchdog/abort enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_master
   import wb_pkg::*;
#(
   parameter int ADDR_W          = WB_ADDR_W,
   parameter int DATA_W          = WB_DATA_W,
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [ADDR_W-1:0]   cmd_addr_i,
   input  logic [DATA_W-1:0]   cmd_data_i,
   input  logic [DATA_W/8-1:0] cmd_sel_i,
   output logic                rsp_valid_o,
   output logic                rsp_we_o,
   output logic [DATA_W-1:0]   rsp_data_o,
   output logic                rsp_err_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [ADDR_W-1:0]   wb_addr_o,
   output logic [DATA_W-1:0]   wb_data_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   input  logic [DATA_W-1:0]   wb_data_i,
   input  logic                wb_ack_i,
   input  logic                wb_stall_i,
   output logic                spurious_ack_o
);

   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic              r_stb;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [SEL_W-1:0]  r_sel;
   logic              r_spurious;
   wbm_state_t        r_state;
   wbm_state_t        w_state_nxt;

   logic [CNT_W-1:0]  w_cnt;
   logic              w_tag;
   logic              w_abort;
   logic              w_issue;
   logic              w_ack_ok;
   logic              w_ready;
   logic              w_accept;
   logic              w_pop;
   logic              w_timeout;
   logic              w_stb_nxt;
   logic              w_busy_nxt;

   assign w_abort  = (r_state == ABORT);
   assign w_issue  = r_stb & ~wb_stall_i;
   assign w_ack_ok = wb_ack_i & (w_cnt != '0) & ~w_abort;
   // Abort drains one tag per cycle as an error response.
   assign w_pop    = w_ack_ok | (w_abort & (w_cnt != '0));

   assign w_ready  = rst_n & (~r_stb | ~wb_stall_i) & ~w_abort & ~w_timeout &
                     ((int'(w_cnt) + int'(w_issue & ~w_ack_ok)) < MAX_OUTSTANDING);
   assign w_accept = cmd_valid_i & w_ready;

   assign w_stb_nxt  = w_timeout ? 1'b0 : (w_accept ? 1'b1 : (w_issue ? 1'b0 : r_stb));
   assign w_busy_nxt = w_stb_nxt |
                       ((int'(w_cnt) + int'(w_issue) - int'(w_pop)) != 0);

   wb_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_issue),
      .i_push_data (r_we),
      .i_pop       (w_pop),
      .o_pop_data  (w_tag),
      .o_count     (w_cnt)
   );

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] r_wd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd <= '0;
      end else if ((r_state == ACTIVE) && (w_cnt != '0) && !wb_ack_i) begin
         r_wd <= r_wd + 1'b1;
      end else begin
         r_wd <= '0;
      end
   end

   assign w_timeout = (r_state == ACTIVE) & (w_cnt != '0) & ~wb_ack_i &
                      (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
   assign rsp_err_o = w_abort & w_pop;
`else
   assign w_timeout = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = ACTIVE;
         ACTIVE:  begin
            if (w_timeout)        w_state_nxt = ABORT;
            else if (!w_busy_nxt) w_state_nxt = IDLE;
         end
         ABORT:   if (int'(w_cnt) <= 1) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stb      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_sel      <= '0;
         r_spurious <= 1'b0;
         r_state    <= IDLE;
      end else begin
         r_stb   <= w_stb_nxt;
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_we   <= cmd_we_i;
            r_addr <= cmd_addr_i;
            r_data <= cmd_data_i;
            r_sel  <= cmd_sel_i;
         end
         if (wb_ack_i && (w_cnt == '0) && !w_abort) begin
            r_spurious <= 1'b1;
         end
      end
   end

   assign cmd_ready_o    = w_ready;
   assign wb_cyc_o       = (r_stb | (w_cnt != '0)) & ~w_abort;
   assign wb_stb_o       = r_stb;
   assign wb_we_o        = r_we;
   assign wb_addr_o      = r_addr;
   assign wb_data_o      = r_data;
   assign wb_sel_o       = r_sel;
   assign rsp_valid_o    = w_pop;
   assign rsp_we_o       = w_pop & w_tag;
   assign rsp_data_o     = (w_ack_ok & ~w_tag) ? wb_data_i : '0;
   assign spurious_ack_o = r_spurious;

endmodule

// File: tb/tb_wishbone_master.sv
// Directed self-checking bench for wishbone_master.
module tb_wishbone_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic [10:0] cmd_addr_i;
   logic [31:0] cmd_data_i;
   logic [3:0]  cmd_sel_i;
   logic        rsp_valid_o;
   logic        rsp_we_o;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [10:0] wb_addr_o;
   logic [31:0] wb_data_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_data_i;
   logic        wb_ack_i;
   logic        wb_stall_i;
   logic        spurious_ack_o;

   int n_checks = 0;
   int n_errors = 0;

   wishbone_master #(
      .ADDR_W          (11),
      .DATA_W          (32),
      .MAX_OUTSTANDING (2),
      .TIMEOUT_CYCLES  (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid_i    (cmd_valid_i),
      .cmd_ready_o    (cmd_ready_o),
      .cmd_we_i       (cmd_we_i),
      .cmd_addr_i     (cmd_addr_i),
      .cmd_data_i     (cmd_data_i),
      .cmd_sel_i      (cmd_sel_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_we_o       (rsp_we_o),
      .rsp_data_o     (rsp_data_o),
      .rsp_err_o      (rsp_err_o),
      .wb_cyc_o       (wb_cyc_o),
      .wb_stb_o       (wb_stb_o),
      .wb_we_o        (wb_we_o),
      .wb_addr_o      (wb_addr_o),
      .wb_data_o      (wb_data_o),
      .wb_sel_o       (wb_sel_o),
      .wb_data_i      (wb_data_i),
      .wb_ack_i       (wb_ack_i),
      .wb_stall_i     (wb_stall_i),
      .spurious_ack_o (spurious_ack_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cmd_set(input logic we, input logic [10:0] addr,
                          input logic [31:0] data, input logic [3:0] sel);
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_addr_i  = addr;
      cmd_data_i  = data;
      cmd_sel_i   = sel;
   endtask

   initial begin
      rst_n       = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'b0;
      cmd_addr_i  = '0;
      cmd_data_i  = '0;
      cmd_sel_i   = '0;
      wb_data_i   = '0;
      wb_ack_i    = 1'b0;
      wb_stall_i  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", 32'(cmd_ready_o), 32'd0);
      chk("rst_cyc",   32'(wb_cyc_o),    32'd0);
      chk("rst_stb",   32'(wb_stb_o),    32'd0);
      chk("rst_spur",  32'(spurious_ack_o), 32'd0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("ready_after_rst", 32'(cmd_ready_o), 32'd1);

      // Single write, 1-cycle ack
      @(negedge clk); cmd_set(1'b1, 11'h004, 32'hDEADBEEF, 4'hF); #1;
      chk("t1_ready", 32'(cmd_ready_o), 32'd1);
      @(negedge clk); cmd_valid_i = 1'b0; #1;
      chk("t1_stb",  32'(wb_stb_o),  32'd1);
      chk("t1_cyc",  32'(wb_cyc_o),  32'd1);
      chk("t1_addr", 32'(wb_addr_o), 32'h004);
      chk("t1_data", wb_data_o,      32'hDEADBEEF);
      chk("t1_sel",  32'(wb_sel_o),  32'hF);
      chk("t1_we",   32'(wb_we_o),   32'd1);
      chk("t1_norsp", 32'(rsp_valid_o), 32'd0);
      @(negedge clk); wb_ack_i = 1'b1; wb_data_i = 32'h12345678; #1;
      chk("t1_stb_low", 32'(wb_stb_o), 32'd0);
      chk("t1_cyc2",    32'(wb_cyc_o), 32'd1);
      chk("t1_rsp",     32'(rsp_valid_o), 32'd1);
      chk("t1_rsp_we",  32'(rsp_we_o),    32'd1);
      chk("t1_rsp_data", rsp_data_o,      32'd0);
      chk("t1_rsp_err", 32'(rsp_err_o),   32'd0);
      @(negedge clk); wb_ack_i = 1'b0; #1;
      chk("t1_cyc_drop", 32'(wb_cyc_o), 32'd0);
      chk("t1_rsp_end",  32'(rsp_valid_o), 32'd0);

      // Back-to-back reads, ack one cycle after each issue
      @(negedge clk); cmd_set(1'b0, 11'h000, 32'h0, 4'hF); #1;
      chk("t2_ready0", 32'(cmd_ready_o), 32'd1);
      @(negedge clk); cmd_set(1'b0, 11'h400, 32'h0, 4'hF); #1;
      chk("t2_stb0",   32'(wb_stb_o),  32'd1);
      chk("t2_addr0",  32'(wb_addr_o), 32'h000);
      chk("t2_ready1", 32'(cmd_ready_o), 32'd1);
      @(negedge clk); cmd_valid_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'hA5A50001; #1;
      chk("t2_stb1",   32'(wb_stb_o),  32'd1);
      chk("t2_addr1",  32'(wb_addr_o), 32'h400);
      chk("t2_rsp0",   32'(rsp_valid_o), 32'd1);
      chk("t2_rdata0", rsp_data_o,     32'hA5A50001);
      chk("t2_rwe0",   32'(rsp_we_o),  32'd0);
      @(negedge clk); wb_data_i = 32'h5A5A0002; #1;
      chk("t2_stb_low", 32'(wb_stb_o), 32'd0);
      chk("t2_cyc_cont", 32'(wb_cyc_o), 32'd1);
      chk("t2_rsp1",   32'(rsp_valid_o), 32'd1);
      chk("t2_rdata1", rsp_data_o,     32'h5A5A0002);
      @(negedge clk); wb_ack_i = 1'b0; #1;
      chk("t2_cyc_drop", 32'(wb_cyc_o), 32'd0);

      // First request stalled for 3 cycles
      @(negedge clk); wb_stall_i = 1'b1; cmd_set(1'b1, 11'h010, 32'h11223344, 4'h3); #1;
      chk("t3_ready0", 32'(cmd_ready_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); cmd_valid_i = 1'b0; #1;
         chk("t3_stb_hold",  32'(wb_stb_o),  32'd1);
         chk("t3_addr_hold", 32'(wb_addr_o), 32'h010);
         chk("t3_data_hold", wb_data_o,      32'h11223344);
         chk("t3_ready_low", 32'(cmd_ready_o), 32'd0);
      end
      @(negedge clk); wb_stall_i = 1'b0; #1;
      chk("t3_stb_issue", 32'(wb_stb_o), 32'd1);
      chk("t3_ready_iss", 32'(cmd_ready_o), 32'd1);
      @(negedge clk); wb_ack_i = 1'b1; #1;
      chk("t3_stb_low", 32'(wb_stb_o), 32'd0);
      chk("t3_rsp",     32'(rsp_valid_o), 32'd1);
      chk("t3_rsp_we",  32'(rsp_we_o),    32'd1);
      @(negedge clk); wb_ack_i = 1'b0; #1;
      chk("t3_cyc_drop", 32'(wb_cyc_o), 32'd0);

      // Acks withheld: outstanding limit of 2
      @(negedge clk); cmd_set(1'b0, 11'h020, 32'h0, 4'hF); #1;
      @(negedge clk); cmd_set(1'b0, 11'h024, 32'h0, 4'hF); #1;
      chk("t4_addrA",  32'(wb_addr_o), 32'h020);
      chk("t4_readyA", 32'(cmd_ready_o), 32'd1);
      @(negedge clk); cmd_set(1'b0, 11'h028, 32'h0, 4'hF); #1;
      chk("t4_addrB",  32'(wb_addr_o), 32'h024);
      chk("t4_readyB", 32'(cmd_ready_o), 32'd0);
      @(negedge clk); #1;
      chk("t4_stb_low", 32'(wb_stb_o), 32'd0);
      chk("t4_full",    32'(cmd_ready_o), 32'd0);
      chk("t4_cyc",     32'(wb_cyc_o), 32'd1);
      @(negedge clk); cmd_valid_i = 1'b0; #1;
      chk("t4_full2",   32'(cmd_ready_o), 32'd0);
      @(negedge clk); wb_ack_i = 1'b1; wb_data_i = 32'hAAAA0020; #1;
      chk("t4_no3rd",  32'(wb_stb_o), 32'd0);
      chk("t4_rspA",   32'(rsp_valid_o), 32'd1);
      chk("t4_rdataA", rsp_data_o, 32'hAAAA0020);
      @(negedge clk); wb_data_i = 32'hBBBB0024; #1;
      chk("t4_ready1", 32'(cmd_ready_o), 32'd1);
      chk("t4_rspB",   32'(rsp_valid_o), 32'd1);
      chk("t4_rdataB", rsp_data_o, 32'hBBBB0024);
      @(negedge clk); wb_ack_i = 1'b0; #1;
      chk("t4_cyc_drop", 32'(wb_cyc_o), 32'd0);
      chk("t4_rsp_end",  32'(rsp_valid_o), 32'd0);

      // Reset during a pending request
      @(negedge clk); cmd_set(1'b1, 11'h7FC, 32'hCAFEF00D, 4'hF); #1;
      @(negedge clk); cmd_valid_i = 1'b0; #1;
      chk("mr_stb", 32'(wb_stb_o), 32'd1);
      rst_n = 1'b0; #1;
      chk("mr_cyc",  32'(wb_cyc_o),  32'd0);
      chk("mr_stb0", 32'(wb_stb_o),  32'd0);
      chk("mr_addr", 32'(wb_addr_o), 32'h0);
      @(negedge clk); rst_n = 1'b1; #1;

      // Ack while idle
      @(negedge clk); wb_ack_i = 1'b1; wb_data_i = 32'hFFFFFFFF; #1;
      chk("sp_norsp", 32'(rsp_valid_o), 32'd0);
      @(negedge clk); wb_ack_i = 1'b0; #1;
      chk("sp_set", 32'(spurious_ack_o), 32'd1);
      @(negedge clk); #1;
      chk("sp_sticky", 32'(spurious_ack_o), 32'd1);
      rst_n = 1'b0; #1;
      chk("sp_clear", 32'(spurious_ack_o), 32'd0);
      @(negedge clk); rst_n = 1'b1; #1;

`ifdef WB_MASTER_TIMEOUT_EN
      begin
         bit seen;
         seen = 1'b0;
         @(negedge clk); cmd_set(1'b0, 11'h100, 32'h0, 4'hF); #1;
         @(negedge clk); cmd_valid_i = 1'b0; #1;
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); #1;
            if (rsp_valid_o) seen = 1'b1;
         end
         chk("to_rsp", 32'(seen), 32'd1);
         chk("to_err", 32'(rsp_err_o), 32'd1);
         chk("to_cyc", 32'(wb_cyc_o), 32'd0);
         @(negedge clk); #1;
         chk("to_rsp_end", 32'(rsp_valid_o), 32'd0);
         chk("to_ready",   32'(cmd_ready_o), 32'd1);
         cmd_set(1'b1, 11'h104, 32'h0BADBEEF, 4'hF);
         @(negedge clk); cmd_valid_i = 1'b0; #1;
         chk("to_next_stb", 32'(wb_stb_o), 32'd1);
         @(negedge clk); wb_ack_i = 1'b1; #1;
         chk("to_next_rsp", 32'(rsp_valid_o), 32'd1);
         chk("to_next_err", 32'(rsp_err_o), 32'd0);
         @(negedge clk); wb_ack_i = 1'b0; #1;
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
